// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in/serial-out serializer.
// The helpers take MAX_W-wide operands, so callers zero-extend their words to MAX_W first.
package piso_pkg;

  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_PAR  = 2'd2
  } state_t;

  // Zero-extension leaves the XOR of the real data bits unchanged.
  function automatic logic even_parity(input logic [MAX_W-1:0] w);
    return ^w;
  endfunction

  // Returns the bit sent at position pos, counting from the first bit on the line.
  function automatic logic bit_at(input logic [MAX_W-1:0] w, input int unsigned width,
                                  input logic msb, input int unsigned pos);
    logic [MAX_W-1:0] sh;
    sh = w >> (msb ? (width - 32'd1 - pos) : pos);
    return sh[0];
  endfunction

endpackage

// File: rtl/piso_hold_reg.sv
// One-entry holding buffer: a second word waits here while the shifter is busy.
module piso_hold_reg #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_wr_msb,
  input  logic             i_rd_en,
  output logic             o_full,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_rd_msb
);

  logic             r_full;
  logic [WIDTH-1:0] r_data;
  logic             r_msb;

  // When a read and a write coincide, the new word replaces the one being read and the entry stays full.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_full <= 1'b0;
      r_data <= '0;
      r_msb  <= 1'b0;
    end else if (i_wr_en) begin
      r_full <= 1'b1;
      r_data <= i_wr_data;
      r_msb  <= i_wr_msb;
    end else if (i_rd_en) begin
      r_full <= 1'b0;
    end
  end

  assign o_full    = r_full;
  assign o_rd_data = r_data;
  assign o_rd_msb  = r_msb;

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with a valid/ready load port and a one-word holding buffer.
// Words can follow each other with no gap, each with its own bit order and an optional even-parity bit.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int PARITY_EN = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] data,
  input  logic             msb_first,
  input  logic             shift_en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_word;
  logic             r_msb;
  logic             r_ser_out;
  logic             r_ser_valid;
  logic             r_done;

  logic             w_full;
  logic [WIDTH-1:0] w_hold_data;
  logic             w_hold_msb;
  logic             w_accept;
  logic             w_consume;
  logic             w_data_last;
  logic             w_last;
  logic             w_load;
  logic             w_hold_wr;
  logic             w_hold_rd;
  logic [WIDTH-1:0] w_src_data;
  logic             w_src_msb;
  logic             w_first_bit;
  logic             w_next_bit;
  logic             w_parity;
  state_t           w_nx_state;
  logic [CW-1:0]    w_nx_cnt;
  logic [WIDTH-1:0] w_nx_word;
  logic             w_nx_msb;
  logic             w_nx_out;
  logic             w_nx_valid;

  piso_hold_reg #(.WIDTH(WIDTH)) u_hold (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_wr_en   (w_hold_wr),
    .i_wr_data (data),
    .i_wr_msb  (msb_first),
    .i_rd_en   (w_hold_rd),
    .o_full    (w_full),
    .o_rd_data (w_hold_data),
    .o_rd_msb  (w_hold_msb)
  );

  // A word enters the shifter from the holding buffer if it is full, otherwise straight from the port.
  always_comb begin
    w_accept    = load_valid && !w_full;
    w_consume   = r_ser_valid && shift_en;
    w_data_last = w_consume && (r_state == ST_DATA) && (r_cnt == CW'(WIDTH - 1));
    w_last      = (w_data_last && (PARITY_EN == 0)) || (w_consume && (r_state == ST_PAR));
    w_load      = (w_accept && (r_state == ST_IDLE)) || (w_last && (w_full || w_accept));
    w_hold_rd   = w_last && w_full;
    w_hold_wr   = w_accept && !w_load;
    w_src_data  = w_full ? w_hold_data : data;
    w_src_msb   = w_full ? w_hold_msb : msb_first;
    w_first_bit = bit_at(MAX_W'(w_src_data), 32'(WIDTH), w_src_msb, 32'd0);
    w_next_bit  = bit_at(MAX_W'(r_word), 32'(WIDTH), r_msb, 32'(r_cnt) + 32'd1);
    w_parity    = even_parity(MAX_W'(r_word));
  end

  // Next shifter state: load a new word, end the current one, or step to the next bit.
  always_comb begin
    w_nx_state = r_state;
    w_nx_cnt   = r_cnt;
    w_nx_word  = r_word;
    w_nx_msb   = r_msb;
    w_nx_out   = r_ser_out;
    w_nx_valid = r_ser_valid;
    if (w_load) begin
      w_nx_state = ST_DATA;
      w_nx_cnt   = '0;
      w_nx_word  = w_src_data;
      w_nx_msb   = w_src_msb;
      w_nx_out   = w_first_bit;
      w_nx_valid = 1'b1;
    end else if (w_last) begin
      w_nx_state = ST_IDLE;
      w_nx_cnt   = '0;
      w_nx_out   = 1'b0;
      w_nx_valid = 1'b0;
    end else if (w_consume && (r_state == ST_DATA)) begin
      if (w_data_last) begin
        w_nx_state = ST_PAR;
        w_nx_cnt   = '0;
        w_nx_out   = w_parity;
      end else begin
        w_nx_cnt = r_cnt + CW'(1);
        w_nx_out = w_next_bit;
      end
    end else begin
      w_nx_state = r_state;
    end
  end

  // State and output registers; reset aborts any word in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_word      <= '0;
      r_msb       <= 1'b0;
      r_ser_out   <= 1'b0;
      r_ser_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_nx_state;
      r_cnt       <= w_nx_cnt;
      r_word      <= w_nx_word;
      r_msb       <= w_nx_msb;
      r_ser_out   <= w_nx_out;
      r_ser_valid <= w_nx_valid;
      r_done      <= w_last;
    end
  end

  assign load_ready = !w_full;
  assign ser_out    = r_ser_out;
  assign ser_valid  = r_ser_valid;
  assign busy       = (r_state != ST_IDLE) || w_full;
  assign done       = r_done;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: instance 0 without parity, instance 1 with parity, both 8 bits wide.
// A word-queue model is compared against both instances every cycle; directed tests also check hand-computed values.
module tb_piso_serializer;

  typedef struct packed {
    logic [7:0] d;
    logic       m;
  } wd_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       lv  [2];
  logic [7:0] dat [2];
  logic       msb [2];
  logic       se  [2];
  logic       rdy [2];
  logic       so  [2];
  logic       sv  [2];
  logic       bsy [2];
  logic       dn  [2];

  int total = 0;
  int bad   = 0;

  // model: up to two words per instance (shifter + holding buffer)
  wd_t  slot  [2][2];
  int   mcnt  [2];
  int   mpos  [2];
  logic ev [2], eo [2], er [2], eb [2], ed [2];

  // capture of consumed bits and done pulses
  logic [63:0] cap   [2];
  int          ncap  [2];
  int          ndone [2];

  piso_serializer #(.WIDTH(8), .PARITY_EN(0)) dut0 (
    .clk(clk), .reset(rst), .load_valid(lv[0]), .load_ready(rdy[0]), .data(dat[0]),
    .msb_first(msb[0]), .shift_en(se[0]), .ser_out(so[0]), .ser_valid(sv[0]),
    .busy(bsy[0]), .done(dn[0]));

  piso_serializer #(.WIDTH(8), .PARITY_EN(1)) dut1 (
    .clk(clk), .reset(rst), .load_valid(lv[1]), .load_ready(rdy[1]), .data(dat[1]),
    .msb_first(msb[1]), .shift_en(se[1]), .ser_out(so[1]), .ser_valid(sv[1]),
    .busy(bsy[1]), .done(dn[1]));

  initial forever #5 clk = ~clk;

  function automatic logic exp_bit(input wd_t w, input int p);
    logic [7:0] t;
    if (p >= 8) return ^w.d;
    t = w.d >> (w.m ? (7 - p) : p);
    return t[0];
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // model update on each edge from the inputs held over that edge
  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        mcnt[k] = 0;
        mpos[k] = 0;
        ed[k]   = 1'b0;
      end else begin
        logic cons, acc;
        cons  = (mcnt[k] > 0) && se[k];
        acc   = lv[k] && (mcnt[k] < 2);
        ed[k] = 1'b0;
        if (cons) begin
          mpos[k]++;
          if (mpos[k] == 8 + k) begin
            slot[k][0] = slot[k][1];
            mcnt[k]--;
            mpos[k] = 0;
            ed[k]   = 1'b1;
          end
        end
        if (acc) begin
          slot[k][mcnt[k]] = '{d: dat[k], m: msb[k]};
          mcnt[k]++;
        end
      end
      ev[k] = (mcnt[k] > 0);
      eo[k] = (mcnt[k] > 0) ? exp_bit(slot[k][0], mpos[k]) : 1'b0;
      er[k] = (mcnt[k] < 2);
      eb[k] = (mcnt[k] > 0);
    end
  end

  // compare both instances against the model and record consumed bits
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      total++;
      if ({sv[k], sv[k] & so[k], rdy[k], bsy[k], dn[k]} !== {ev[k], ev[k] & eo[k], er[k], eb[k], ed[k]}) begin
        bad++;
        $display("FAIL model%0d t=%0t: got v/o/rdy/busy/done=%b%b%b%b%b expected %b%b%b%b%b", k, $time,
                 sv[k], so[k], rdy[k], bsy[k], dn[k], ev[k], eo[k], er[k], eb[k], ed[k]);
      end
      if (sv[k] && se[k]) begin
        cap[k]  = {cap[k][62:0], so[k]};
        ncap[k] = ncap[k] + 1;
      end
      if (dn[k]) ndone[k] = ndone[k] + 1;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // sends one word on instance k with shift_en high, then checks the captured bits
  task automatic send_one(input int k, input logic [7:0] d, input logic m, input int nbits,
                          input logic [63:0] exp_bits, input string name);
    int b0, d0;
    b0 = ncap[k];
    d0 = ndone[k];
    se[k] = 1'b1; lv[k] = 1'b1; dat[k] = d; msb[k] = m;
    cyc();
    lv[k] = 1'b0;
    repeat (nbits + 3) cyc();
    check({name, "_nbits"}, 64'(ncap[k] - b0), 64'(nbits));
    check({name, "_bits"}, cap[k] & ((64'd1 << nbits) - 64'd1), exp_bits);
    check({name, "_done"}, 64'(ndone[k] - d0), 64'd1);
  endtask

  initial begin
    int b0, d0;
    for (int k = 0; k < 2; k++) begin
      lv[k] = 1'b0; dat[k] = 8'h00; msb[k] = 1'b0; se[k] = 1'b0;
      cap[k] = 64'd0; ncap[k] = 0; ndone[k] = 0;
    end
    rst = 1'b1;
    #1;
    check("reset_outs", {63'd0, rdy[0]} << 4 | {60'd0, sv[0], so[0], bsy[0], dn[0]}, 64'h10);
    repeat (2) cyc();
    rst = 1'b0;
    cyc();

    send_one(0, 8'hA5, 1'b1, 8, 64'hA5, "a5_msb");
    send_one(0, 8'h01, 1'b0, 8, 64'h80, "01_lsb");
    send_one(0, 8'h80, 1'b1, 8, 64'h80, "80_msb");
    send_one(1, 8'h07, 1'b0, 9, 64'h1C1, "par_07");
    send_one(1, 8'h03, 1'b0, 9, 64'h180, "par_03");

    // back-to-back with a third offer while the buffer is full
    b0 = ncap[0]; d0 = ndone[0];
    se[0] = 1'b1; lv[0] = 1'b1; dat[0] = 8'hF0; msb[0] = 1'b1;
    cyc();
    dat[0] = 8'h0F;
    cyc();
    check("b2b_ready_low", {63'd0, rdy[0]}, 64'd0);
    dat[0] = 8'h55;
    repeat (6) cyc();
    check("b2b_ready_still_low", {63'd0, rdy[0]}, 64'd0);
    lv[0] = 1'b0;
    repeat (12) cyc();
    check("b2b_nbits", 64'(ncap[0] - b0), 64'd16);
    check("b2b_bits", cap[0] & 64'hFFFF, 64'hF00F);
    check("b2b_done", 64'(ndone[0] - d0), 64'd2);

    // stall for five cycles after three bits
    b0 = ncap[0];
    lv[0] = 1'b1; dat[0] = 8'hB2; msb[0] = 1'b1;
    cyc();
    lv[0] = 1'b0;
    repeat (3) cyc();
    se[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("stall_frozen", {62'd0, sv[0], so[0]}, 64'd3);
    end
    se[0] = 1'b1;
    repeat (10) cyc();
    check("stall_bits", cap[0] & 64'hFF, 64'hB2);
    check("stall_nbits", 64'(ncap[0] - b0), 64'd8);

    // reset mid-word with a word in the holding buffer
    b0 = ncap[0]; d0 = ndone[0];
    lv[0] = 1'b1; dat[0] = 8'hC3; msb[0] = 1'b1;
    cyc();
    dat[0] = 8'hFF;
    cyc();
    lv[0] = 1'b0;
    repeat (3) cyc();
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_outs", {59'd0, rdy[0], sv[0], so[0], bsy[0], dn[0]}, 64'h10);
    repeat (2) cyc();
    rst = 1'b0;
    repeat (12) cyc();
    check("rst_nbits", 64'(ncap[0] - b0), 64'd4);
    check("rst_bits", cap[0] & 64'hF, 64'hC);
    check("rst_no_done", 64'(ndone[0] - d0), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parametrised parallel-in/serial-out serializer with a valid/ready load port, a one-word holding buffer for gap-free back-to-back words, per-word bit order and optional even-parity append. It sits between a word-wide producer and a bit-serial transmitter. The downstream side consumes one bit per cycle in which `shift_en` is high.

## Interface
- `WIDTH`, 8: data word width, ≥2.
- `PARITY_EN`, 0: 1 appends an even-parity bit after the data bits.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `load_valid` input 1: producer offers `data` / `msb_first`.
- `load_ready` output 1: block can accept a word; registered, equals "holding buffer empty".
- `data` input WIDTH: parallel word, sampled on accept.
- `msb_first` input 1: bit order for this word, sampled with `data`; 1 sends bit WIDTH-1 first.
- `shift_en` input 1: downstream consumes the current bit this cycle.
- `ser_out` output 1: current serial bit, registered.
- `ser_valid` output 1: `ser_out` holds a valid bit.
- `busy` output 1: shifter or holding buffer occupied.
- `done` output 1: one-cycle pulse on the edge where a word's final bit (parity if enabled) is consumed.

## Operation
- Accept: `load_valid && load_ready` at a rising edge.
- Consume: `ser_valid && shift_en` at a rising edge. `shift_en` is ignored while `ser_valid` = 0.
- States (shared enum): IDLE, DATA, PAR. PAR exists only if PARITY_EN = 1.
- Bit counter: $clog2(WIDTH) bits. It counts consumed data bits 0..WIDTH-1.
- IDLE:
  - An accept with the holding buffer empty bypasses into the shifter.
  - The shifter loads the word and order flag.
  - `ser_out` takes the first bit, `ser_valid` = 1, state becomes DATA.
- DATA:
  - Each consume advances `ser_out` to the next bit in the latched order.
  - On consuming data bit WIDTH-1:
    - With PARITY_EN, go to PAR; `ser_out` = XOR of the word's data bits.
    - Otherwise the word ends.
- PAR: consuming the parity bit ends the word.
- Word end (the consume of the final bit):
  - `done` pulses.
  - If the holding buffer is full, its word moves into the shifter on the same edge: first bit valid, state DATA, no gap cycle, `load_ready` rises the next cycle.
  - Otherwise, if an accept occurs on the same edge, the word bypasses directly into the shifter: no gap.
  - Otherwise, go to IDLE and `ser_valid` = 0.
- An accept while the shifter is busy and the buffer is empty writes the holding buffer. `load_ready` goes to 0 on the next edge.
- `load_valid` while `load_ready` = 0 is ignored, and `data` is not sampled.
- `msb_first` or `data` changing mid-word has no effect on the word in flight.
- `busy` = (state ≠ IDLE) OR holding buffer full.

## Timing
- Reset values (asynchronous assert; release is synchronous to `clk` in the environment):
  - `load_ready` = 1.
  - `ser_out` = 0, `ser_valid` = 0, `busy` = 0, `done` = 0.
  - State = IDLE, counter = 0, holding buffer empty.
- An accept at edge N into an idle block gives `ser_valid` = 1 with the first bit after edge N (latency 1).
- With `shift_en` held high, a word occupies exactly WIDTH + PARITY_EN consecutive cycles.
- Back-to-back words have zero idle cycles between them.
- With `shift_en` low, `ser_out`, `ser_valid`, the counter and the state hold indefinitely.
- Reset asserted mid-word aborts the word immediately:
  - No `done` pulse.
  - The holding buffer is discarded.
  - Outputs go to reset values without waiting for a clock edge.
- The maximum number of words held is 2 (shifter plus holding buffer).

## Structure
- Package `piso_pkg`:
  - State enum (IDLE, DATA, PAR).
  - Function `even_parity(logic [WIDTH-1:0])`, or a parity helper parametrised at the call site.
  - Bit-select helper for MSB/LSB order.
- Sub-module `piso_hold_reg`:
  - Holds the one-entry holding buffer: data, order flag and full flag.
  - Provides write on accept, read on transfer, and simultaneous read+write behaviour.
- Top level contains the FSM, bit counter and shift register.

## Test plan
- Reset then accept 8'hA5 with `msb_first` = 1 and `shift_en` = 1:
  - `ser_out` reads 1,0,1,0,0,1,0,1 over 8 cycles.
  - `done` pulses on the 8th consume.
  - `ser_valid` drops on the following cycle.
- Accept 8'h01 with `msb_first` = 0:
  - Bits 1,0,0,0,0,0,0,0.
  - Repeat with 8'h80 and `msb_first` = 1: same bit sequence.
- PARITY_EN = 1, word 8'h07: 9 bits 1,1,1,0,0,0,0,0,1 (LSB first, parity 1). Word 8'h03: parity bit 0.
- Back-to-back 8'hF0 then 8'h0F, the second accepted while the first shifts, `shift_en` = 1:
  - 16 consecutive valid bits.
  - `done` pulses after bits 8 and 16.
  - `load_ready` = 0 while the buffer is full.
  - A third `load_valid` during that window is not accepted.
- Stall with `shift_en` = 0 for 5 cycles after bit 3: `ser_out` and `ser_valid` stay frozen, and the sequence resumes with bit 4 intact.
- Reset asserted after bit 4 of 8'hC3 with a word buffered:
  - Outputs go to 0 asynchronously and `load_ready` = 1.
  - No `done` pulse.
  - The buffered word is never emitted.
